// File: rtl/bp_pkg.sv
// Shared types, constants and address-split helpers for the branch target buffer.
// The table geometry here sets the defaults used by branch_predictor_table.
package bp_pkg;

  localparam int BP_ENTRIES = 16;
  localparam int BP_PC_W    = 32;
  localparam int BP_IDX_W   = $clog2(BP_ENTRIES);
  localparam int BP_PC_OFS  = 2;
  localparam int BP_TAG_W   = BP_PC_W - BP_IDX_W - BP_PC_OFS;
  localparam int BP_STAT_W  = 16;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_PC_W-1:0]  target;
    logic                pred;
  } bp_entry_t;

  // pc[1:0] never participates: instructions are word aligned.
  function automatic logic [BP_IDX_W-1:0] bp_idx(input logic [BP_PC_W-1:0] pc);
    return pc[BP_PC_OFS +: BP_IDX_W];
  endfunction

  function automatic logic [BP_TAG_W-1:0] bp_tag(input logic [BP_PC_W-1:0] pc);
    return pc[BP_PC_W-1 -: BP_TAG_W];
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; sticks at all-ones.
module bp_sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/branch_predictor_table.sv
// Direct-mapped BTB with 1-bit prediction, combinational IF lookup and stage-2 copies.
// Define BP_STATS_EN to add saturating hit/flush statistics outputs.
module branch_predictor_table
  import bp_pkg::*;
#(
  parameter int ENTRIES = BP_ENTRIES,
  parameter int PC_W    = BP_PC_W
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [PC_W-1:0] i_pc_if,
  input  logic            i_stall,
  input  logic            i_flush_s1,
  input  logic            i_wr_target,
  input  logic            i_wr_pred,
  input  logic            i_taken,
  input  logic [PC_W-1:0] i_branch_target,
  output logic            o_hit,
  output logic            o_pred,
  output logic [PC_W-1:0] o_target_pred,
  output logic            o_hit_d,
  output logic            o_pred_d,
  output logic [PC_W-1:0] o_pc_d
`ifdef BP_STATS_EN
  ,
  output logic [BP_STAT_W-1:0] o_stat_hits,
  output logic [BP_STAT_W-1:0] o_stat_flushes
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);

  bp_entry_t r_table [ENTRIES];

  logic            r_hit_d;
  logic            r_pred_d;
  logic [PC_W-1:0] r_pc_d;

  logic [IDX_W-1:0]    w_rd_idx;
  logic [BP_TAG_W-1:0] w_rd_tag;
  bp_entry_t           w_rd_entry;
  logic                w_hit;

  logic [IDX_W-1:0]    w_wr_idx;
  logic [BP_TAG_W-1:0] w_wr_tag;
  bp_entry_t           w_wr_entry;
  logic                w_wr_match;

  assign w_rd_idx   = bp_idx(i_pc_if);
  assign w_rd_tag   = bp_tag(i_pc_if);
  assign w_rd_entry = r_table[w_rd_idx];
  assign w_hit      = w_rd_entry.valid && (w_rd_entry.tag == w_rd_tag);

  assign o_hit         = w_hit;
  assign o_pred        = w_hit ? w_rd_entry.pred : 1'b0;
  assign o_target_pred = w_hit ? w_rd_entry.target : '0;

  assign w_wr_idx   = bp_idx(r_pc_d);
  assign w_wr_tag   = bp_tag(r_pc_d);
  assign w_wr_entry = r_table[w_wr_idx];
  assign w_wr_match = w_wr_entry.valid && (w_wr_entry.tag == w_wr_tag);

  // Only valid bits are reset; a reset edge also drops any write presented with it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_table[i].valid <= 1'b0;
      end
    end else if (i_wr_target) begin
      r_table[w_wr_idx] <= '{valid: 1'b1, tag: w_wr_tag, target: i_branch_target, pred: i_taken};
    end else if (i_wr_pred && w_wr_match) begin
      r_table[w_wr_idx].pred <= i_taken;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_hit_d  <= 1'b0;
      r_pred_d <= 1'b0;
      r_pc_d   <= '0;
    end else if (i_flush_s1) begin
      r_hit_d  <= 1'b0;
      r_pred_d <= 1'b0;
    end else if (!i_stall) begin
      r_hit_d  <= w_hit;
      r_pred_d <= o_pred;
      r_pc_d   <= i_pc_if;
    end
  end

  assign o_hit_d  = r_hit_d;
  assign o_pred_d = r_pred_d;
  assign o_pc_d   = r_pc_d;

`ifdef BP_STATS_EN
  bp_sat_counter #(.W(BP_STAT_W)) u_stat_hits (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_hit && !i_stall),
    .o_count (o_stat_hits)
  );

  bp_sat_counter #(.W(BP_STAT_W)) u_stat_flushes (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (i_flush_s1),
    .o_count (o_stat_flushes)
  );
`endif

endmodule

// File: tb/tb_branch_predictor_table.sv
// Directed bench for branch_predictor_table; stats checks run when BP_STATS_EN is defined.
module tb_branch_predictor_table;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_if;
  logic        stall;
  logic        flush_s1;
  logic        wr_target;
  logic        wr_pred;
  logic        taken;
  logic [31:0] branch_target;
  logic        hit;
  logic        pred;
  logic [31:0] target_pred;
  logic        hit_d;
  logic        pred_d;
  logic [31:0] pc_d;
`ifdef BP_STATS_EN
  logic [15:0] stat_hits;
  logic [15:0] stat_flushes;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  branch_predictor_table dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_pc_if         (pc_if),
    .i_stall         (stall),
    .i_flush_s1      (flush_s1),
    .i_wr_target     (wr_target),
    .i_wr_pred       (wr_pred),
    .i_taken         (taken),
    .i_branch_target (branch_target),
    .o_hit           (hit),
    .o_pred          (pred),
    .o_target_pred   (target_pred),
    .o_hit_d         (hit_d),
    .o_pred_d        (pred_d),
    .o_pc_d          (pc_d)
`ifdef BP_STATS_EN
    ,
    .o_stat_hits     (stat_hits),
    .o_stat_flushes  (stat_flushes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; pc_if = 32'h0; stall = 1'b0; flush_s1 = 1'b0;
    wr_target = 1'b0; wr_pred = 1'b0; taken = 1'b0; branch_target = 32'h0;
    tick(2);
    rst_n = 1'b1; pc_if = 32'h40; #1;
    n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit actual %b required 0", hit); end
    n_checks++; if (pred !== 1'b0) begin n_fail++; $display("FAIL reset_pred actual %b required 0", pred); end
    n_checks++; if (target_pred !== 32'h0) begin n_fail++; $display("FAIL reset_target actual %h required 0", target_pred); end
    n_checks++; if (hit_d !== 1'b0) begin n_fail++; $display("FAIL reset_hit_d actual %b required 0", hit_d); end
    n_checks++; if (pred_d !== 1'b0) begin n_fail++; $display("FAIL reset_pred_d actual %b required 0", pred_d); end
    n_checks++; if (pc_d !== 32'h0) begin n_fail++; $display("FAIL reset_pc_d actual %h required 0", pc_d); end
  endtask

  task automatic test_allocate;
    pc_if = 32'h40; tick();
    n_checks++; if (pc_d !== 32'h40) begin n_fail++; $display("FAIL alloc_pc_d actual %h required 40", pc_d); end
    wr_target = 1'b1; taken = 1'b1; branch_target = 32'h100; #1;
    n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL alloc_old_hit actual %b required 0", hit); end
    tick(); wr_target = 1'b0; #1;
    n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL alloc_hit actual %b required 1", hit); end
    n_checks++; if (pred !== 1'b1) begin n_fail++; $display("FAIL alloc_pred actual %b required 1", pred); end
    n_checks++; if (target_pred !== 32'h100) begin n_fail++; $display("FAIL alloc_target actual %h required 100", target_pred); end
    tick();
    n_checks++; if (hit_d !== 1'b1) begin n_fail++; $display("FAIL alloc_hit_d actual %b required 1", hit_d); end
    n_checks++; if (pred_d !== 1'b1) begin n_fail++; $display("FAIL alloc_pred_d actual %b required 1", pred_d); end
  endtask

  task automatic test_alias;
    pc_if = 32'h80; #1;
    n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL alias_hit actual %b required 0", hit); end
    n_checks++; if (target_pred !== 32'h0) begin n_fail++; $display("FAIL alias_target actual %h required 0", target_pred); end
    pc_if = 32'h40; #1;
    n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL alias_orig_hit actual %b required 1", hit); end
    n_checks++; if (target_pred !== 32'h100) begin n_fail++; $display("FAIL alias_orig_target actual %h required 100", target_pred); end
  endtask

  task automatic test_pred_update;
    pc_if = 32'h40; tick();
    wr_pred = 1'b1; taken = 1'b0; tick(); wr_pred = 1'b0; #1;
    n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL wrp_hit actual %b required 1", hit); end
    n_checks++; if (pred !== 1'b0) begin n_fail++; $display("FAIL wrp_pred actual %b required 0", pred); end
    n_checks++; if (target_pred !== 32'h100) begin n_fail++; $display("FAIL wrp_target actual %h required 100", target_pred); end
    pc_if = 32'h80; tick();
    wr_pred = 1'b1; taken = 1'b1; tick(); wr_pred = 1'b0;
    pc_if = 32'h40; #1;
    n_checks++; if (pred !== 1'b0) begin n_fail++; $display("FAIL wrp_miss_pred actual %b required 0", pred); end
    pc_if = 32'h80; #1;
    n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL wrp_no_alloc actual %b required 0", hit); end
  endtask

  task automatic test_flush_stall;
    pc_if = 32'h40; tick();
    wr_pred = 1'b1; taken = 1'b1; tick(); wr_pred = 1'b0;
    tick();
    n_checks++; if (hit_d !== 1'b1 || pred_d !== 1'b1) begin n_fail++; $display("FAIL fs_pre actual %b%b required 11", hit_d, pred_d); end
    flush_s1 = 1'b1; pc_if = 32'h80; tick(); flush_s1 = 1'b0;
    n_checks++; if (hit_d !== 1'b0 || pred_d !== 1'b0) begin n_fail++; $display("FAIL flush_clear actual %b%b required 00", hit_d, pred_d); end
    n_checks++; if (pc_d !== 32'h40) begin n_fail++; $display("FAIL flush_pc_hold actual %h required 40", pc_d); end
    pc_if = 32'h40; tick();
    stall = 1'b1; pc_if = 32'h80; tick(2);
    n_checks++; if (hit_d !== 1'b1 || pred_d !== 1'b1) begin n_fail++; $display("FAIL stall_hold actual %b%b required 11", hit_d, pred_d); end
    n_checks++; if (pc_d !== 32'h40) begin n_fail++; $display("FAIL stall_pc_hold actual %h required 40", pc_d); end
    flush_s1 = 1'b1; tick(); flush_s1 = 1'b0; stall = 1'b0;
    n_checks++; if (hit_d !== 1'b0 || pred_d !== 1'b0) begin n_fail++; $display("FAIL flush_over_stall actual %b%b required 00", hit_d, pred_d); end
    n_checks++; if (pc_d !== 32'h40) begin n_fail++; $display("FAIL flush_over_stall_pc actual %h required 40", pc_d); end
  endtask

  task automatic test_conflict;
    pc_if = 32'h80; tick();
    wr_target = 1'b1; taken = 1'b0; branch_target = 32'h200; pc_if = 32'h40; #1;
    n_checks++; if (hit !== 1'b1 || target_pred !== 32'h100) begin n_fail++; $display("FAIL conflict_old actual %b/%h required 1/100", hit, target_pred); end
    tick(); wr_target = 1'b0; #1;
    n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL conflict_evict actual %b required 0", hit); end
    pc_if = 32'h80; #1;
    n_checks++; if (hit !== 1'b1 || pred !== 1'b0 || target_pred !== 32'h200) begin n_fail++; $display("FAIL conflict_new actual %b%b/%h required 10/200", hit, pred, target_pred); end
  endtask

  task automatic test_index_tag;
    pc_if = 32'h1234_5678; tick();
    wr_target = 1'b1; taken = 1'b1; wr_pred = 1'b1; branch_target = 32'hCAFE_0000; tick();
    wr_target = 1'b0; wr_pred = 1'b0;
    pc_if = 32'h1234_567B; #1;
    n_checks++; if (hit !== 1'b1 || target_pred !== 32'hCAFE_0000) begin n_fail++; $display("FAIL lowbits_ignored actual %b/%h required 1/cafe0000", hit, target_pred); end
    pc_if = 32'h9234_5678; #1;
    n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL tag_msb actual %b required 0", hit); end
    pc_if = 32'h80; #1;
    n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL other_index_kept actual %b required 1", hit); end
  endtask

  task automatic test_reset_mid;
    pc_if = 32'h80; tick();
    wr_target = 1'b1; branch_target = 32'h300; rst_n = 1'b0; tick();
    wr_target = 1'b0; rst_n = 1'b1; #1;
    n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL rst_mid_hit actual %b required 0", hit); end
    n_checks++; if (pc_d !== 32'h0) begin n_fail++; $display("FAIL rst_mid_pc_d actual %h required 0", pc_d); end
    pc_if = 32'h1234_5678; #1;
    n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL rst_clears_all actual %b required 0", hit); end
    pc_if = 32'h80; tick();
    wr_target = 1'b1; taken = 1'b1; tick(); wr_target = 1'b0; #1;
    n_checks++; if (hit !== 1'b1 || target_pred !== 32'h300) begin n_fail++; $display("FAIL rst_realloc actual %b/%h required 1/300", hit, target_pred); end
  endtask

`ifdef BP_STATS_EN
  task automatic test_stats;
    rst_n = 1'b0; stall = 1'b0; flush_s1 = 1'b0; pc_if = 32'h0; tick(2);
    rst_n = 1'b1; #1;
    n_checks++; if (stat_hits !== 16'h0 || stat_flushes !== 16'h0) begin n_fail++; $display("FAIL stats_reset actual %h/%h required 0/0", stat_hits, stat_flushes); end
    pc_if = 32'h40; tick();
    wr_target = 1'b1; taken = 1'b1; branch_target = 32'h100; tick(); wr_target = 1'b0;
    tick(3);
    stall = 1'b1; tick();
    flush_s1 = 1'b1; tick(2); flush_s1 = 1'b0; stall = 1'b0;
    n_checks++; if (stat_hits !== 16'd3) begin n_fail++; $display("FAIL stats_hits actual %0d required 3", stat_hits); end
    n_checks++; if (stat_flushes !== 16'd2) begin n_fail++; $display("FAIL stats_flushes actual %0d required 2", stat_flushes); end
    tick(65540);
    n_checks++; if (stat_hits !== 16'hFFFF) begin n_fail++; $display("FAIL stats_saturate actual %h required ffff", stat_hits); end
    tick(3);
    n_checks++; if (stat_hits !== 16'hFFFF) begin n_fail++; $display("FAIL stats_hold actual %h required ffff", stat_hits); end
    n_checks++; if (stat_flushes !== 16'd2) begin n_fail++; $display("FAIL stats_flush_hold actual %0d required 2", stat_flushes); end
  endtask
`endif

  initial begin
    test_reset();
    test_allocate();
    test_alias();
    test_pred_update();
    test_flush_stall();
    test_conflict();
    test_index_tag();
    test_reset_mid();
`ifdef BP_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor_table.md
Name: branch_predictor_table

Overview:
- Direct-mapped branch target buffer with one 1-bit prediction per entry. Sits directly upstream of the branch control unit.
- Looks up the fetch PC in IF and produces H, P and the predicted target for the PC mux.
- Registers hit/prediction/PC into the stage-2 copies Hd, Pd and pc_d.
- Applies the Wrt/Wrp write-backs that the control unit issues when a branch resolves.

Parameters:
- ENTRIES, 16, number of table entries; must be a power of two.
- PC_W, 32, PC and target width.
- IDX_W, $clog2(ENTRIES), index width; derived, never overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- pc_if  in  PC_W  fetch-stage PC to look up.
- stall  in  1  hold the stage-2 registers.
- flush_s1  in  1  from control unit; bubbles the stage-2 registers.
- wr_target  in  1  Wrt: allocate/overwrite the entry for pc_d.
- wr_pred  in  1  Wrp: update the prediction bit for pc_d.
- taken  in  1  c: resolved branch outcome of the stage-2 instruction.
- branch_target  in  PC_W  resolved target of the stage-2 branch.
- hit  out  1  H: valid entry with matching tag for pc_if.
- pred  out  1  P: stored prediction; 0 when hit=0.
- target_pred  out  PC_W  stored target; 0 when hit=0.
- hit_d  out  1  Hd: registered hit.
- pred_d  out  1  Pd: registered pred.
- pc_d  out  PC_W  registered pc_if.

Behaviour:
- Address split: index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]. pc[1:0] is ignored.
- Each entry holds valid, tag, target and pred.
- Lookup is purely combinational from pc_if, with zero-cycle latency.
  - hit = valid[idx] & (tag[idx] == tag(pc_if)).
  - pred and target_pred are forced to 0 on a miss.
- Stage-2 registers, in priority order at each rising edge:
  - !rst_n: hit_d, pred_d and pc_d go to 0.
  - Else flush_s1: hit_d and pred_d go to 0; pc_d is held.
  - Else !stall: hit_d, pred_d and pc_d capture hit, pred and pc_if.
  - Otherwise all three hold.
- Writes always use the index and tag of pc_d and take effect at the next edge.
  - wr_target=1: valid=1, tag=tag(pc_d), target=branch_target, pred=taken. wr_pred is then irrelevant.
  - wr_pred=1 with wr_target=0: pred=taken, but only if the entry is valid and its tag matches pc_d. Otherwise no change; the table is never allocated by a prediction-only write.
  - Writes proceed regardless of stall and flush_s1.
- Write to the index being looked up in the same cycle: the lookup returns the old contents. There is no bypass.
- Reset: all valid bits clear on the edge with rst_n=0. Tag, target and pred storage is not reset.
  - A reset asserted mid-operation discards any write presented in that cycle.
- After reset, every lookup misses until a wr_target occurs.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined: adds two outputs, stat_hits[15:0] and stat_flushes[15:0]. Both are 16-bit saturating counters, cleared on reset.
  - stat_hits increments on an edge where hit & !stall.
  - stat_flushes increments on each edge with flush_s1=1.
  - Both hold at 16'hFFFF.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

Decomposition:
- Package bp_pkg holds:
  - the bp_entry_t struct (valid, tag, target, pred);
  - index/tag extraction functions;
  - the PC-offset constant 2;
  - the counter width 16 used by BP_STATS_EN.
- Sub-module bp_sat_counter is a parametric-width saturating counter, instantiated twice under BP_STATS_EN.
- The table array stays inline.

Test Plan (ENTRIES=16, PC_W=32):
- Reset: rst_n=0 for 2 cycles, then pc_if=0x40 -> hit=0, pred=0, target_pred=0, hit_d=0, pc_d=0.
- Allocate:
  - Stimulus: pc_if=0x40 for one edge (pc_d=0x40), then wr_target=1, taken=1, branch_target=0x100 for one edge; then pc_if=0x40.
  - Required response: hit=1, pred=1, target_pred=0x100. One edge later: hit_d=1, pred_d=1.
- Alias: with 0x40 allocated, pc_if=0x80 (same index 0, tag 2) -> hit=0. The 0x40 entry is unchanged.
- Prediction-only update:
  - pc_d=0x40, wr_pred=1, wr_target=0, taken=0 -> next lookup of 0x40 gives hit=1, pred=0, target_pred=0x100.
  - Same stimulus with pc_d=0x80 -> no change.
- Flush and stall:
  - hit_d=1, then flush_s1=1 -> hit_d=0, pred_d=0 next cycle, pc_d held.
  - stall=1 with pc_if changing -> hit_d, pred_d and pc_d all held.
  - flush_s1=1 with stall=1 -> flush wins.
- Same-cycle conflict and stats:
  - wr_target to index 0 while pc_if=0x40 -> hit reflects the old entry that cycle and the new entry the next.
  - With BP_STATS_EN defined: 3 unstalled hits and 2 flushes -> stat_hits=3, stat_flushes=2.
  - Preloaded stat_hits=16'hFFFF -> stays at 16'hFFFF.
